axi_request_serializer: RTL and testbench
=========================================

Name: axi_request_serializer

Overview:
- Downstream neighbour of the non-AXI scheduling domain.
- When the scheduler raises its activate signal, it latches the packet presented by the selector and pulses consumed back to the scheduler so the winning queue pops.
- It then replays the packet as one AXI4 master transaction: AR only for reads; AW plus 1–4 W beats for writes.
- B and R responses bypass this block; the top-level AXI domain routes them.

Parameters:
- DATA_SIZE, 678, packet width; must equal HDR_SIZE + MAX_BEATS*(DATA_WIDTH/8) + MAX_BEATS*DATA_WIDTH.
- ID_WIDTH, 16, AXI ID width.
- ADDR_WIDTH, 40, AXI address width.
- DATA_WIDTH, 128, AXI data width.
- USER_WIDTH, 16, AXI user width.
- MAX_BEATS, 4, maximum beats carried per packet.

Ports:
- clock  in  1  single clock for all logic.
- reset  in  1  asynchronous, active-low reset.
- selector_to_serializer_packet  in  DATA_SIZE  packet from the selector.
- scheduler_to_serializer_activate_signal  in  1  packet valid, sampled only in IDLE.
- serializer_to_scheduler_consumed  out  1  one-cycle pulse when a packet is latched.
- busy  out  1  high in any state other than IDLE.
- protocol_error  out  1  sticky; set when a packet carries len>MAX_BEATS-1; cleared only by reset.
- m_axi_aw{id,addr,len,size,burst,lock,cache,prot,qos,region,user,valid}  out  AXI4 widths (len 8, size 3, burst 2, lock 1, cache/qos/region 4, prot 3).
- m_axi_awready  in  1.
- m_axi_w{data,strb,last,valid}  out  DATA_WIDTH, DATA_WIDTH/8, 1, 1.
- m_axi_wready  in  1.
- m_axi_ar{id,addr,len,size,burst,lock,cache,prot,qos,region,user,valid}  out  as AW.
- m_axi_arready  in  1.

Behaviour:
- Packet layout, LSB first:
  - header [101:0] = is_write[0], id[16:1], addr[56:17], len[64:57], size[67:65], burst[69:68], lock[70], cache[74:71], prot[77:75], qos[81:78], region[85:82], user[101:86];
  - strb[b] at [102+16b +: 16];
  - data[b] at [166+128b +: 128].
- Reset (asserted low, asynchronous): state=IDLE; all valid outputs, wlast, consumed, busy and protocol_error are 0; the packet register, beat counter and AXI payload outputs are 0.
- Reset mid-transaction abandons the transaction immediately. The packet is lost, because consumed has already popped it.
- IDLE:
  - If activate=1 at a rising edge, latch the full packet and go to ADDR.
  - consumed=1 for exactly the next cycle (first ADDR cycle).
  - activate is ignored in every state except IDLE.
- ADDR:
  - For a write, awvalid=1 and the AW fields come from the latched header.
  - For a read, arvalid=1 and the AR fields come from the latched header.
  - Effective length L = len[1:0]; awlen/arlen = {6'b0, L}.
  - If len[7:2]!=0, set protocol_error in the cycle of the latch+1 and continue using L.
  - valid stays high, with the payload stable, until ready. On handshake: reads go to IDLE; writes go to WDATA with beat=0.
  - AXI ready already high in the first ADDR cycle completes that cycle (one-cycle ADDR).
- WDATA:
  - wvalid=1, wdata=data[beat], wstrb=strb[beat], wlast=(beat==L).
  - On a wvalid&wready handshake: if beat==L go to IDLE, else beat++.
  - The 2-bit beat counter never wraps past L.
- AW is always completed before the first W beat; the block never overlaps transactions.
- Best case: a new packet can be latched on the cycle after returning to IDLE.
  - Write of L+1 beats: 1 latch + 1 ADDR + (L+1) W cycles.
  - Read: 2 cycles latch-to-IDLE.
- The block does not need outputs registered twice. AXI outputs are driven from the latched register and state; there is no combinational path from the input packet to the AXI outputs.
- busy=(state!=IDLE).

Decomposition:
- Shared package memoredf_pkg:
  - HDR_SIZE=102;
  - packed struct request_header_t with the fields above in that order;
  - localparams for STRB_OFFSET=102 and DATA_OFFSET=166;
  - typedef enum serializer_state_t {IDLE, ADDR, WDATA}.
- Unpacking is done by casting the latched header to request_header_t.
- No sub-module; the beat mux is an indexed part-select inside the block.

Test Plan:
- Read, id=0x0003, addr=0x00_8000_0040, len=0, activate one cycle, arready=1 → arvalid high for 1 cycle with arlen=0; consumed pulses once, one cycle after activate; no AW/W activity; busy low 2 cycles after activate.
- Write, len=3, data beats 0x11..,0x22..,0x33..,0x44.., strb 0xFFFF each, awready=wready=1 → AW then 4 consecutive W beats in order; wlast only on the 0x44.. beat; back to IDLE.
- Write, len=1, awready low 5 cycles, then wready toggling 1/0 → awvalid and payload held stable 5 cycles; each W beat held until ready; exactly 2 beats.
- activate held high continuously across two packets → second latch only after IDLE re-entry; exactly one consumed pulse per packet.
- Write with len=0x05 → protocol_error=1 and stays set; awlen=1; 2 W beats sent.
- Reset asserted during beat 1 of a 4-beat write → wvalid/awvalid/busy drop to 0 asynchronously; after release the block idles until the next activate.

Source files
------------

// File: rtl/memoredf_pkg.sv
// Shared types for the request serializer: packet header layout, packet offsets and FSM states.
// The header struct is declared MSB first so a cast of packet[101:0] places is_write at bit 0.
package memoredf_pkg;

    localparam int unsigned HDR_SIZE    = 102;
    localparam int unsigned STRB_OFFSET = 102;
    localparam int unsigned DATA_OFFSET = 166;

    typedef struct packed {
        logic [15:0] user;
        logic [3:0]  region;
        logic [3:0]  qos;
        logic [2:0]  prot;
        logic [3:0]  cache;
        logic        lock;
        logic [1:0]  burst;
        logic [2:0]  size;
        logic [7:0]  len;
        logic [39:0] addr;
        logic [15:0] id;
        logic        is_write;
    } request_header_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADDR  = 2'd1,
        WDATA = 2'd2
    } serializer_state_t;

endpackage

// File: rtl/axi_request_serializer.sv
// Latches one scheduled packet and replays it as a single AXI4 master transaction:
// AR alone for reads, AW followed by 1-4 W beats for writes.
module axi_request_serializer
    import memoredf_pkg::*;
#(
    parameter int unsigned DATA_SIZE  = 678,
    parameter int unsigned ID_WIDTH   = 16,
    parameter int unsigned ADDR_WIDTH = 40,
    parameter int unsigned DATA_WIDTH = 128,
    parameter int unsigned USER_WIDTH = 16,
    parameter int unsigned MAX_BEATS  = 4
) (
    input  logic                    clock,
    input  logic                    reset,

    input  logic [DATA_SIZE-1:0]    selector_to_serializer_packet,
    input  logic                    scheduler_to_serializer_activate_signal,
    output logic                    serializer_to_scheduler_consumed,
    output logic                    busy,
    output logic                    protocol_error,

    output logic [ID_WIDTH-1:0]     m_axi_awid,
    output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [7:0]              m_axi_awlen,
    output logic [2:0]              m_axi_awsize,
    output logic [1:0]              m_axi_awburst,
    output logic                    m_axi_awlock,
    output logic [3:0]              m_axi_awcache,
    output logic [2:0]              m_axi_awprot,
    output logic [3:0]              m_axi_awqos,
    output logic [3:0]              m_axi_awregion,
    output logic [USER_WIDTH-1:0]   m_axi_awuser,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,

    output logic [DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                    m_axi_wlast,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,

    output logic [ID_WIDTH-1:0]     m_axi_arid,
    output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [7:0]              m_axi_arlen,
    output logic [2:0]              m_axi_arsize,
    output logic [1:0]              m_axi_arburst,
    output logic                    m_axi_arlock,
    output logic [3:0]              m_axi_arcache,
    output logic [2:0]              m_axi_arprot,
    output logic [3:0]              m_axi_arqos,
    output logic [3:0]              m_axi_arregion,
    output logic [USER_WIDTH-1:0]   m_axi_aruser,
    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    if (DATA_SIZE != HDR_SIZE + MAX_BEATS * STRB_WIDTH + MAX_BEATS * DATA_WIDTH) begin : g_size_check
        $error("DATA_SIZE does not match header + strobes + data");
    end

    serializer_state_t     state_q, state_d;
    logic [DATA_SIZE-1:0]  packet_q;
    logic [1:0]            beat_q, beat_d;
    logic                  consumed_q;
    logic                  perr_q;

    request_header_t       hdr;
    request_header_t       hdr_in;
    logic [1:0]            eff_len;
    logic                  latch;
    logic                  last_beat;
    logic                  aw_hs, ar_hs, w_hs;
    int unsigned           beat_idx;

    assign hdr       = request_header_t'(packet_q[HDR_SIZE-1:0]);
    assign hdr_in    = request_header_t'(selector_to_serializer_packet[HDR_SIZE-1:0]);
    assign eff_len   = hdr.len[1:0];
    assign latch     = (state_q == IDLE) && scheduler_to_serializer_activate_signal;
    assign last_beat = (beat_q == eff_len);
    assign beat_idx  = 32'(beat_q);

    assign aw_hs = m_axi_awvalid && m_axi_awready;
    assign ar_hs = m_axi_arvalid && m_axi_arready;
    assign w_hs  = m_axi_wvalid && m_axi_wready;

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        unique case (state_q)
            IDLE: begin
                if (scheduler_to_serializer_activate_signal) begin
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (aw_hs) begin
                    state_d = WDATA;
                    beat_d  = 2'd0;
                end else if (ar_hs) begin
                    state_d = IDLE;
                end
            end
            WDATA: begin
                if (w_hs) begin
                    if (last_beat) begin
                        state_d = IDLE;
                        beat_d  = 2'd0;
                    end else begin
                        beat_d = beat_q + 2'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                beat_d  = 2'd0;
            end
        endcase
    end

    // Error is judged on the incoming header so it is visible in the first ADDR cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            packet_q   <= '0;
            beat_q     <= 2'd0;
            consumed_q <= 1'b0;
            perr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            consumed_q <= latch;
            if (latch) begin
                packet_q <= selector_to_serializer_packet;
                if (hdr_in.len > 8'(MAX_BEATS - 1)) begin
                    perr_q <= 1'b1;
                end
            end
        end
    end

    assign serializer_to_scheduler_consumed = consumed_q;
    assign busy                             = (state_q != IDLE);
    assign protocol_error                   = perr_q;

    assign m_axi_awvalid  = (state_q == ADDR) && hdr.is_write;
    assign m_axi_awid     = hdr.id;
    assign m_axi_awaddr   = hdr.addr;
    assign m_axi_awlen    = {6'b0, eff_len};
    assign m_axi_awsize   = hdr.size;
    assign m_axi_awburst  = hdr.burst;
    assign m_axi_awlock   = hdr.lock;
    assign m_axi_awcache  = hdr.cache;
    assign m_axi_awprot   = hdr.prot;
    assign m_axi_awqos    = hdr.qos;
    assign m_axi_awregion = hdr.region;
    assign m_axi_awuser   = hdr.user;

    assign m_axi_arvalid  = (state_q == ADDR) && !hdr.is_write;
    assign m_axi_arid     = hdr.id;
    assign m_axi_araddr   = hdr.addr;
    assign m_axi_arlen    = {6'b0, eff_len};
    assign m_axi_arsize   = hdr.size;
    assign m_axi_arburst  = hdr.burst;
    assign m_axi_arlock   = hdr.lock;
    assign m_axi_arcache  = hdr.cache;
    assign m_axi_arprot   = hdr.prot;
    assign m_axi_arqos    = hdr.qos;
    assign m_axi_arregion = hdr.region;
    assign m_axi_aruser   = hdr.user;

    assign m_axi_wvalid = (state_q == WDATA);
    assign m_axi_wlast  = (state_q == WDATA) && last_beat;
    assign m_axi_wdata  = packet_q[DATA_OFFSET + beat_idx * DATA_WIDTH +: DATA_WIDTH];
    assign m_axi_wstrb  = packet_q[STRB_OFFSET + beat_idx * STRB_WIDTH +: STRB_WIDTH];

endmodule

// File: tb/tb_axi_request_serializer.sv
// Scoreboard bench for axi_request_serializer: expected AW/W/AR traffic is queued as packets are
// presented and compared against every handshake seen on the master ports.
module tb_axi_request_serializer;

    logic         clock = 1'b0;
    logic         reset;
    logic [677:0] packet;
    logic         activate;
    logic         consumed, busy, protocol_error;

    logic [15:0]  awid, arid, awuser, aruser;
    logic [39:0]  awaddr, araddr;
    logic [7:0]   awlen, arlen;
    logic [2:0]   awsize, arsize, awprot, arprot;
    logic [1:0]   awburst, arburst;
    logic         awlock, arlock;
    logic [3:0]   awcache, arcache, awqos, arqos, awregion, arregion;
    logic         awvalid, awready, arvalid, arready;
    logic [127:0] wdata;
    logic [15:0]  wstrb;
    logic         wlast, wvalid, wready;

    always #5 clock = ~clock;

    axi_request_serializer dut (
        .clock                                   (clock),
        .reset                                   (reset),
        .selector_to_serializer_packet           (packet),
        .scheduler_to_serializer_activate_signal (activate),
        .serializer_to_scheduler_consumed        (consumed),
        .busy                                    (busy),
        .protocol_error                          (protocol_error),
        .m_axi_awid     (awid),     .m_axi_awaddr  (awaddr),  .m_axi_awlen    (awlen),
        .m_axi_awsize   (awsize),   .m_axi_awburst (awburst), .m_axi_awlock   (awlock),
        .m_axi_awcache  (awcache),  .m_axi_awprot  (awprot),  .m_axi_awqos    (awqos),
        .m_axi_awregion (awregion), .m_axi_awuser  (awuser),  .m_axi_awvalid  (awvalid),
        .m_axi_awready  (awready),
        .m_axi_wdata    (wdata),    .m_axi_wstrb   (wstrb),   .m_axi_wlast    (wlast),
        .m_axi_wvalid   (wvalid),   .m_axi_wready  (wready),
        .m_axi_arid     (arid),     .m_axi_araddr  (araddr),  .m_axi_arlen    (arlen),
        .m_axi_arsize   (arsize),   .m_axi_arburst (arburst), .m_axi_arlock   (arlock),
        .m_axi_arcache  (arcache),  .m_axi_arprot  (arprot),  .m_axi_arqos    (arqos),
        .m_axi_arregion (arregion), .m_axi_aruser  (aruser),  .m_axi_arvalid  (arvalid),
        .m_axi_arready  (arready)
    );

    int total = 0;
    int bad   = 0;

    logic [100:0] aw_q[$];
    logic [100:0] ar_q[$];
    logic [144:0] w_q[$];

    logic [127:0] bd[4];
    logic [15:0]  bs[4];

    int n_consumed = 0, n_aw = 0, n_w = 0, n_ar = 0, aw_wait = 0, n_busy = 0;
    logic wtoggle = 1'b0;

    task automatic check_eq(input string tag, input logic [159:0] got, input logic [159:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Build a packet from fields and queue the traffic the spec says it must produce.
    task automatic prep(input logic w, input logic [15:0] id, input logic [39:0] addr,
                        input logic [7:0] len);
        logic [15:0]  user = id ^ 16'hA5A5;
        logic [100:0] tuple;
        int           l = int'(len[1:0]);
        packet          = '0;
        packet[0]       = w;
        packet[16:1]    = id;
        packet[56:17]   = addr;
        packet[64:57]   = len;
        packet[67:65]   = 3'd4;
        packet[69:68]   = 2'b01;
        packet[70]      = 1'b0;
        packet[74:71]   = 4'h3;
        packet[77:75]   = 3'h2;
        packet[81:78]   = 4'h1;
        packet[85:82]   = 4'h5;
        packet[101:86]  = user;
        for (int b = 0; b < 4; b++) begin
            packet[102 + 16 * b +: 16]  = bs[b];
            packet[166 + 128 * b +: 128] = bd[b];
        end
        tuple = {user, 4'h5, 4'h1, 3'h2, 4'h3, 1'b0, 2'b01, 3'd4, {6'b0, len[1:0]}, addr, id};
        if (w) begin
            aw_q.push_back(tuple);
            for (int b = 0; b <= l; b++) w_q.push_back({bs[b], b == l, bd[b]});
        end else begin
            ar_q.push_back(tuple);
        end
    endtask

    task automatic go();
        activate = 1'b1;
        @(posedge clock);
        #1;
        activate = 1'b0;
        packet   = ~packet;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200; i++) begin
            @(posedge clock);
            #1;
            if (!busy && aw_q.size() == 0 && w_q.size() == 0 && ar_q.size() == 0) break;
        end
        check_eq("drain", {busy, aw_q.size() != 0, w_q.size() != 0, ar_q.size() != 0}, 0);
    endtask

    task automatic fill(input logic [7:0] base);
        for (int b = 0; b < 4; b++) begin
            bd[b] = {16{base + 8'(b)}};
            bs[b] = 16'hFFFF ^ 16'(b * 16'h0101);
        end
    endtask

    always @(posedge clock) begin
        #1;
        if (wtoggle) wready = ~wready;
    end

    initial begin : monitor
        logic         aw_hold = 1'b0, w_hold = 1'b0, aw_seen = 1'b0;
        logic [100:0] aw_prev, aw_now, ar_now, exp_t;
        logic [144:0] w_prev, w_now, exp_w;
        forever begin
            @(negedge clock);
            aw_now = {awuser, awregion, awqos, awprot, awcache, awlock, awburst, awsize, awlen,
                      awaddr, awid};
            ar_now = {aruser, arregion, arqos, arprot, arcache, arlock, arburst, arsize, arlen,
                      araddr, arid};
            w_now  = {wstrb, wlast, wdata};
            if (!reset) begin
                aw_hold = 1'b0;
                w_hold  = 1'b0;
                aw_seen = 1'b0;
            end else begin
                if (consumed) n_consumed++;
                if (busy) n_busy++;
                if (awvalid && !awready) aw_wait++;
                if (aw_hold) check_eq("aw_stable", {awvalid, aw_now}, {1'b1, aw_prev});
                if (w_hold) check_eq("w_stable", {wvalid, w_now}, {1'b1, w_prev});
                aw_hold = awvalid && !awready;
                aw_prev = aw_now;
                w_hold  = wvalid && !wready;
                w_prev  = w_now;
                if (awvalid && awready) begin
                    n_aw++;
                    check_eq("aw_no_overlap", aw_seen, 0);
                    check_eq("aw_expected", aw_q.size() != 0, 1);
                    if (aw_q.size() != 0) begin
                        exp_t = aw_q.pop_front();
                        check_eq("aw_payload", aw_now, exp_t);
                    end
                    aw_seen = 1'b1;
                end
                if (wvalid && wready) begin
                    n_w++;
                    check_eq("w_after_aw", aw_seen, 1);
                    check_eq("w_expected", w_q.size() != 0, 1);
                    if (w_q.size() != 0) begin
                        exp_w = w_q.pop_front();
                        check_eq("w_beat", w_now, exp_w);
                    end
                    if (wlast) aw_seen = 1'b0;
                end
                if (arvalid && arready) begin
                    n_ar++;
                    check_eq("ar_expected", ar_q.size() != 0, 1);
                    if (ar_q.size() != 0) begin
                        exp_t = ar_q.pop_front();
                        check_eq("ar_payload", ar_now, exp_t);
                    end
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int base, i;
        reset    = 1'b0;
        activate = 1'b0;
        packet   = '1;
        awready  = 1'b0;
        wready   = 1'b0;
        arready  = 1'b0;
        fill(8'h00);
        repeat (3) @(posedge clock);
        #1;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_consumed", consumed, 0);
        check_eq("rst_valids", {awvalid, wvalid, arvalid, wlast}, 0);
        check_eq("rst_perr", protocol_error, 0);
        check_eq("rst_payload", {awaddr, awid, awlen, araddr}, 0);
        check_eq("rst_wdata", {wdata, wstrb}, 0);
        reset = 1'b1;
        @(posedge clock);
        #1;

        // Single-beat read with arready already high.
        arready = 1'b1;
        prep(1'b0, 16'h0003, 40'h00_8000_0040, 8'h00);
        base = n_consumed;
        go();
        check_eq("rd_consumed", consumed, 1);
        check_eq("rd_arvalid", {arvalid, awvalid, wvalid}, 3'b100);
        check_eq("rd_arlen", arlen, 0);
        check_eq("rd_busy1", busy, 1);
        @(posedge clock);
        #1;
        check_eq("rd_busy2", {busy, consumed, arvalid}, 0);
        wait_idle();
        check_eq("rd_consumed_cnt", n_consumed - base, 1);

        // Four-beat write, always ready: 1 ADDR cycle + 4 back-to-back W cycles.
        awready = 1'b1;
        wready  = 1'b1;
        for (int b = 0; b < 4; b++) begin
            bd[b] = {16{8'(8'h11 * (b + 1))}};
            bs[b] = 16'hFFFF;
        end
        prep(1'b1, 16'h0010, 40'h12_3456_7000, 8'h03);
        base = n_w;
        i    = n_busy;
        go();
        wait_idle();
        check_eq("wr4_beats", n_w - base, 4);
        check_eq("wr4_busy_cycles", n_busy - i, 5);

        // Two-beat write with AW stalled five cycles and wready toggling.
        awready = 1'b0;
        wready  = 1'b0;
        fill(8'h60);
        prep(1'b1, 16'h0BEE, 40'h00_0000_1000, 8'h01);
        base = n_w;
        i    = aw_wait;
        go();
        repeat (5) @(posedge clock);
        #1;
        awready = 1'b1;
        wready  = 1'b1;
        wtoggle = 1'b1;
        check_eq("stall_aw_cycles", aw_wait - i, 5);
        wait_idle();
        wtoggle = 1'b0;
        #2;
        wready = 1'b1;
        check_eq("stall_beats", n_w - base, 2);

        // activate held high across two packets: second latch only after IDLE re-entry.
        fill(8'hA0);
        prep(1'b1, 16'h0101, 40'h00_0000_2000, 8'h00);
        base     = n_consumed;
        activate = 1'b1;
        @(posedge clock);
        #1;
        prep(1'b0, 16'h0202, 40'h00_0000_3000, 8'h02);
        for (i = 0; i < 20; i++) begin
            @(posedge clock);
            #1;
            if (consumed) break;
        end
        activate = 1'b0;
        check_eq("relatch_gap", i, 2);
        wait_idle();
        check_eq("held_consumed_cnt", n_consumed - base, 2);

        // len=5: sticky protocol error, effective length 1.
        fill(8'hC0);
        check_eq("perr_before", protocol_error, 0);
        prep(1'b1, 16'h0505, 40'h00_0000_4000, 8'h05);
        base = n_w;
        go();
        check_eq("perr_set", protocol_error, 1);
        check_eq("perr_awlen", awlen, 1);
        wait_idle();
        check_eq("perr_sticky", protocol_error, 1);
        check_eq("perr_beats", n_w - base, 2);

        // Reset during beat 1 of a four-beat write.
        fill(8'hE0);
        prep(1'b1, 16'h0606, 40'h00_0000_5000, 8'h03);
        base = n_w;
        go();
        for (i = 0; i < 20; i++) begin
            if (n_w == base + 1) break;
            @(posedge clock);
            #1;
        end
        check_eq("mid_beat1", {wvalid, wdata}, {1'b1, bd[1]});
        #1;
        reset = 1'b0;
        #1;
        check_eq("async_drop", {wvalid, awvalid, busy, wlast}, 0);
        check_eq("async_perr_clr", protocol_error, 0);
        w_q.delete();
        @(posedge clock);
        #1;
        reset = 1'b1;
        base  = n_consumed;
        repeat (5) @(posedge clock);
        #1;
        check_eq("post_rst_idle", {busy, awvalid, wvalid, arvalid}, 0);
        check_eq("post_rst_no_latch", n_consumed - base, 0);

        fill(8'h30);
        prep(1'b0, 16'h0707, 40'h00_0000_6000, 8'h01);
        base = n_ar;
        go();
        wait_idle();
        check_eq("post_rst_read", n_ar - base, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
